// File: rtl/lsu.sv
// lsu: load/store unit bridging execute-stage results to a valid/ready memory bus and writeback.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_wen,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_wen,
  output logic        out_fault,
  output logic [3:0]  out_cause
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          wen_q, wen_d;
  logic          rwen_q, rwen_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic          req_wen_q, req_wen_d;
  logic [3:0]    req_wstrb_q, req_wstrb_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_fault_q, out_fault_d, out_reg_wen_q, out_reg_wen_d;
  logic [3:0]    out_cause_q, out_cause_d;
  logic          mem, illegal, misal, acc_fault, busy, fin, tmo;
  logic [3:0]    acc_cause, strb;
  logic [31:0]   wdata, ld_val;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  always_comb begin
    mem       = mem_ren | mem_wen;
    illegal   = (mem_ren & mem_wen)
              | (mem_ren & (funct3 == 3'b011 || funct3[2:1] == 2'b11))
              | (mem_wen & (funct3[2] || funct3[1:0] == 2'b11));
    misal     = (funct3[1:0] == 2'b01 && alu_result[0]) || (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    acc_fault = mem & (illegal | misal);
    acc_cause = illegal ? 4'd2 : mem_wen ? 4'd6 : 4'd4;
    strb      = funct3[1:0] == 2'b00 ? 4'b0001 << alu_result[1:0] :
                funct3[1:0] == 2'b01 ? 4'b0011 << alu_result[1:0] : 4'b1111;
    wdata     = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    byte_v    = resp_rdata[{off_q, 3'b000} +: 8];
    half_v    = resp_rdata[{off_q[1], 4'b0000} +: 16];
    ld_val    = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_v[15]}}, half_v} : resp_rdata;
    busy      = state_q == S_REQ || state_q == S_WAIT;
    fin       = state_q == S_WAIT && resp_valid;
    tmo       = busy && !fin && cnt_q == CW'(TIMEOUT - 1);
  end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    off_d         = off_q;
    f3_d          = f3_q;
    wen_d         = wen_q;
    rwen_d        = rwen_q;
    rd_d          = rd_q;
    req_addr_d    = req_addr_q;
    req_wen_d     = req_wen_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    out_data_d    = out_data_q;
    out_fault_d   = out_fault_q;
    out_cause_d   = out_cause_q;
    out_reg_wen_d = out_reg_wen_q;
    if (state_q == S_IDLE && in_valid) begin
      off_d         = alu_result[1:0];
      f3_d          = funct3;
      wen_d         = mem_wen;
      rwen_d        = reg_wen;
      rd_d          = rd;
      cnt_d         = '0;
      req_addr_d    = {alu_result[31:2], 2'b00};
      req_wen_d     = mem_wen;
      req_wdata_d   = mem_wen ? wdata : 32'd0;
      req_wstrb_d   = mem_wen ? strb : 4'd0;
      state_d       = mem && !acc_fault ? S_REQ : S_DONE;
      out_data_d    = mem ? 32'd0 : alu_result;
      out_fault_d   = acc_fault;
      out_cause_d   = acc_fault ? acc_cause : 4'd0;
      out_reg_wen_d = !mem && reg_wen && rd != 5'd0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
      if (state_q == S_REQ && req_ready)
        state_d = S_WAIT;
      // A timeout is reported exactly like a bus error response.
      if (fin || tmo) begin
        state_d       = S_DONE;
        out_fault_d   = tmo || resp_err;
        out_cause_d   = tmo || resp_err ? (wen_q ? 4'd7 : 4'd5) : 4'd0;
        out_data_d    = tmo || resp_err || wen_q ? 32'd0 : ld_val;
        out_reg_wen_d = !tmo && !resp_err && !wen_q && rwen_q && rd_q != 5'd0;
      end
    end else if (state_q == S_DONE && out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      off_q         <= '0;
      f3_q          <= '0;
      wen_q         <= 1'b0;
      rwen_q        <= 1'b0;
      rd_q          <= '0;
      req_addr_q    <= '0;
      req_wen_q     <= 1'b0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
      out_data_q    <= '0;
      out_fault_q   <= 1'b0;
      out_cause_q   <= '0;
      out_reg_wen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      wen_q         <= wen_d;
      rwen_q        <= rwen_d;
      rd_q          <= rd_d;
      req_addr_q    <= req_addr_d;
      req_wen_q     <= req_wen_d;
      req_wdata_q   <= req_wdata_d;
      req_wstrb_q   <= req_wstrb_d;
      out_data_q    <= out_data_d;
      out_fault_q   <= out_fault_d;
      out_cause_q   <= out_cause_d;
      out_reg_wen_q <= out_reg_wen_d;
    end
  end
  assign in_ready    = state_q == S_IDLE;
  assign req_valid   = state_q == S_REQ;
  assign out_valid   = state_q == S_DONE;
  assign req_addr    = req_addr_q;
  assign req_wen     = req_wen_q;
  assign req_wdata   = req_wdata_q;
  assign req_wstrb   = req_wstrb_q;
  assign out_data    = out_data_q;
  assign out_rd      = rd_q;
  assign out_reg_wen = out_reg_wen_q;
  assign out_fault   = out_fault_q;
  assign out_cause   = out_cause_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a short bus timeout.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] alu_result = '0, store_data = '0;
  logic        mem_ren = 1'b0, mem_wen = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_wen = 1'b0;
  logic        req_valid, req_ready = 1'b1;
  logic [31:0] req_addr, req_wdata;
  logic        req_wen;
  logic [3:0]  req_wstrb;
  logic        resp_valid = 1'b0, resp_err = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_reg_wen, out_fault;
  logic [3:0]  out_cause;
  int tests = 0, fails = 0;
  lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .funct3(funct3), .rd(rd), .reg_wen(reg_wen),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_reg_wen(out_reg_wen), .out_fault(out_fault), .out_cause(out_cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic r, input logic w,
                       input logic [2:0] f, input logic [4:0] d, input logic rw);
    alu_result = a; store_data = sd; mem_ren = r; mem_wen = w; funct3 = f; rd = d; reg_wen = rw;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic resp(input logic [31:0] data, input logic err);
    resp_valid = 1'b1; resp_rdata = data; resp_err = err;
    step();
    resp_valid = 1'b0; resp_err = 1'b0;
  endtask
  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] data, input logic [31:0] exp);
    issue(a, 32'd0, 1'b1, 1'b0, f, 5'd3, 1'b1);
    chk({tag, "_req_addr"}, req_addr, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, {28'd0, req_wstrb}, 32'd0);
    step();
    resp(data, 1'b0);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_cause"}, {28'd0, out_cause}, 32'd0);
    chk({tag, "_rwen"}, {31'd0, out_reg_wen}, 32'd1);
    step();
  endtask
  task automatic bad(input string tag, input logic [31:0] a, input logic r, input logic w,
                     input logic [2:0] f, input logic [3:0] cause);
    issue(a, 32'h55, r, w, f, 5'd7, 1'b1);
    chk({tag, "_reqv"}, {31'd0, req_valid}, 32'd0);
    chk({tag, "_outv"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_fault"}, {31'd0, out_fault}, 32'd1);
    chk({tag, "_cause"}, {28'd0, out_cause}, {28'd0, cause});
    chk({tag, "_rwen"}, {31'd0, out_reg_wen}, 32'd0);
    step();
  endtask
  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wstrb", {28'd0, req_wstrb}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    issue(32'h1234, 32'd0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
    chk("alu_out_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_out_data", out_data, 32'h1234);
    chk("alu_out_rd", {27'd0, out_rd}, 32'd5);
    chk("alu_rwen", {31'd0, out_reg_wen}, 32'd1);
    chk("alu_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("alu_back_idle", {31'd0, in_ready}, 32'd1);
    issue(32'h1234, 32'd0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
    chk("alu_rd0_rwen", {31'd0, out_reg_wen}, 32'd0);
    step();
    load("lb", 3'b000, 32'h8000_0003, 32'h80FF_FFFF, 32'hFFFF_FF80);
    load("lbu", 3'b100, 32'h8000_0003, 32'h80FF_FFFF, 32'h0000_0080);
    load("lh", 3'b001, 32'h8000_0002, 32'h8001_1234, 32'hFFFF_8001);
    load("lhu", 3'b101, 32'h8000_0002, 32'h8001_1234, 32'h0000_8001);
    load("lw", 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    issue(32'h8000_0002, 32'h0000_BEEF, 1'b0, 1'b1, 3'b001, 5'd9, 1'b1);
    chk("sh_wstrb", {28'd0, req_wstrb}, 32'hC);
    chk("sh_wdata", req_wdata, 32'hBEEF_BEEF);
    chk("sh_wen", {31'd0, req_wen}, 32'd1);
    chk("sh_addr", req_addr, 32'h8000_0000);
    step();
    resp(32'd0, 1'b0);
    chk("sh_fault", {31'd0, out_fault}, 32'd0);
    chk("sh_rwen", {31'd0, out_reg_wen}, 32'd0);
    step();
    issue(32'h0000_0101, 32'h1234_5678, 1'b0, 1'b1, 3'b000, 5'd9, 1'b0);
    chk("sb_wstrb", {28'd0, req_wstrb}, 32'h2);
    chk("sb_wdata", req_wdata, 32'h7878_7878);
    step();
    resp(32'd0, 1'b1);
    chk("sb_err_cause", {28'd0, out_cause}, 32'd7);
    step();
    bad("lw_mis", 32'h8000_0002, 1'b1, 1'b0, 3'b010, 4'd4);
    bad("lh_mis", 32'h8000_0001, 1'b1, 1'b0, 3'b101, 4'd4);
    bad("sw_mis", 32'h8000_0001, 1'b0, 1'b1, 3'b010, 4'd6);
    bad("ld_ill", 32'h8000_0000, 1'b1, 1'b0, 3'b011, 4'd2);
    bad("st_ill", 32'h8000_0000, 1'b0, 1'b1, 3'b100, 4'd2);
    bad("both", 32'h8000_0000, 1'b1, 1'b1, 3'b010, 4'd2);
    req_ready = 1'b0;
    issue(32'h0000_0100, 32'd0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_reqv", {31'd0, req_valid}, 32'd1);
      chk("stall_addr", req_addr, 32'h100);
      step();
    end
    req_ready = 1'b1;
    chk("stall_reqv_last", {31'd0, req_valid}, 32'd1);
    step();
    chk("wait_reqv", {31'd0, req_valid}, 32'd0);
    resp(32'h1111_1111, 1'b1);
    chk("err_fault", {31'd0, out_fault}, 32'd1);
    chk("err_cause", {28'd0, out_cause}, 32'd5);
    chk("err_rwen", {31'd0, out_reg_wen}, 32'd0);
    step();
    out_ready = 1'b0;
    issue(32'h0000_0200, 32'd0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
    for (int i = 0; i < 7; i++) step();
    chk("tmo_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    chk("tmo_outv", {31'd0, out_valid}, 32'd1);
    resp_valid = 1'b1; resp_rdata = 32'hABCD_0000;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_fault", {31'd0, out_fault}, 32'd1);
      chk("tmo_cause", {28'd0, out_cause}, 32'd5);
      chk("tmo_data", out_data, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("stray_idle", {31'd0, in_ready}, 32'd1);
    step();
    chk("stray_outv", {31'd0, out_valid}, 32'd0);
    resp_valid = 1'b0;
    issue(32'h0000_0300, 32'd0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_outv", {31'd0, out_valid}, 32'd0);
    chk("mrst_addr", req_addr, 32'd0);
    chk("mrst_data", out_data, 32'd0);
    resp(32'h7777_7777, 1'b0);
    chk("late_outv", {31'd0, out_valid}, 32'd0);
    chk("late_data", out_data, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the bus-wait cycles (REQ+WAIT) before an access is aborted as a fault.
REQ-002 clk  in  1  clock; all state SHALL update on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  execute-stage result valid.
REQ-005 in_ready  out  1  lsu can accept a new op.
REQ-006 alu_result  in  32  effective address, or writeback value for non-memory ops.
REQ-007 store_data  in  32  rs2 value for stores.
REQ-008 mem_ren / mem_wen  in  1 each  load / store op.
REQ-009 funct3  in  3  access size and sign.
REQ-010 rd  in  5  destination register.
REQ-011 reg_wen  in  1  op writes rd.
REQ-012 req_valid  out  1  bus request valid.
REQ-013 req_ready  in  1  bus accepts request.
REQ-014 req_addr  out  32  word-aligned address.
REQ-015 req_wen  out  1  1 = write.
REQ-016 req_wdata  out  32  lane-replicated store data.
REQ-017 req_wstrb  out  4  byte strobes, 0 on reads.
REQ-018 resp_valid  in  1  bus response valid.
REQ-019 resp_rdata  in  32  read data.
REQ-020 resp_err  in  1  bus error with response.
REQ-021 out_valid  out  1  writeback result valid.
REQ-022 out_ready  in  1  writeback accepts.
REQ-023 out_data / out_rd / out_reg_wen  out  32/5/1  writeback payload.
REQ-024 out_fault / out_cause  out  1/4  exception flag, mcause-style code.

Function
REQ-025 FSM states IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-026 Accept on in_valid&&in_ready: latch all inputs; mem op -> REQ, otherwise -> DONE with out_data=alu_result (one cycle latency).
REQ-027 Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-028 Illegal funct3, or mem_ren&&mem_wen both set: no bus access -> DONE, out_fault=1, out_cause=2.
REQ-029 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus access -> DONE, out_fault=1, out_cause=4 load / 6 store.
REQ-030 REQ: req_valid=1; req_addr={addr[31:2],2'b00}, req_wen, req_wdata, req_wstrb SHALL stay stable until the cycle req_ready=1, then -> WAIT.
REQ-031 Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. Data: SB {4{b}}, SH {2{h}}, SW word.
REQ-032 WAIT: on resp_valid -> DONE; resp_valid outside WAIT SHALL be ignored (stray/late responses dropped).
REQ-033 Load result: select byte/half at addr[1:0] from resp_rdata; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-034 resp_err=1 with resp_valid: out_fault=1, out_cause=5 load / 7 store.
REQ-035 Counter clears on entry to REQ, increments each REQ/WAIT cycle; reaching TIMEOUT -> DONE with the REQ-034 fault; req_valid deasserts.
REQ-036 Stores and faults SHALL drive out_reg_wen=0; rd=0 SHALL force out_reg_wen=0.
REQ-037 DONE: out_valid=1, payload held stable until out_ready=1, then -> IDLE (in_ready=1 next cycle); max throughput one op per 2 cycles.
REQ-038 When out_fault=0, out_cause SHALL be 0.

Reset
REQ-039 rst SHALL force IDLE, in_ready=1, req_valid=0, out_valid=0, req_wstrb=0, counter=0, all data/payload outputs 0.
REQ-040 rst mid-transaction SHALL abandon the access; any response returned afterwards SHALL be ignored.

Verification
REQ-041 Non-mem op alu_result=0x1234, rd=5, reg_wen=1, out_ready=1 -> out_valid next cycle, out_data=0x1234, out_rd=5.
REQ-042 LB addr=0x80000003, resp_rdata=0x80FFFFFF -> req_addr=0x80000000, out_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-043 SH addr=0x80000002, store_data=0x0000BEEF -> req_wstrb=4'b1100, req_wdata=0xBEEFBEEF, out_reg_wen=0.
REQ-044 LW addr=0x80000002 -> no req_valid, out_fault=1, out_cause=4.
REQ-045 req_ready low 3 cycles -> req payload stable throughout; resp_err=1 on response -> out_cause=5; no response within TIMEOUT -> fault cause 5, later resp ignored.
REQ-046 out_ready held low 4 cycles in DONE -> out payload stable, in_ready=0; rst asserted in WAIT -> IDLE next cycle, outputs 0.
